// File: rtl/iir_pkg.sv
// Shared constants and types for the IIR coefficient controller.
package iir_pkg;

  localparam int unsigned COEF_W   = 9;
  localparam int unsigned NUM_COEF = 5;

  localparam logic [2:0] ADDR_B0 = 3'd0;
  localparam logic [2:0] ADDR_B1 = 3'd1;
  localparam logic [2:0] ADDR_B2 = 3'd2;
  localparam logic [2:0] ADDR_A1 = 3'd3;
  localparam logic [2:0] ADDR_A2 = 3'd4;

  // 1.0 in Q2.6
  localparam logic [COEF_W-1:0] COEF_ONE = 9'h040;

  typedef enum logic [1:0] {StRun, StDrain, StSwap} state_e;

endpackage

// File: rtl/iir_coef_bank.sv
// Shadow/active coefficient bank. Shadow registers take cfg writes in any state;
// the active set is copied from shadow on the swap cycle only.
// Optional IIR_CTRL_RDBK_EN adds a registered shadow readback port.
module iir_coef_bank
  import iir_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        addr,
  input  logic [COEF_W-1:0] wdata,
  input  logic              swap,
`ifdef IIR_CTRL_RDBK_EN
  output logic [COEF_W-1:0] rdata,
`endif
  output logic [COEF_W-1:0] b0,
  output logic [COEF_W-1:0] b1,
  output logic [COEF_W-1:0] b2,
  output logic [COEF_W-1:0] a1,
  output logic [COEF_W-1:0] a2
);

  logic [COEF_W-1:0] shadow_q [NUM_COEF];
  logic [COEF_W-1:0] shadow_d [NUM_COEF];
  logic [COEF_W-1:0] active_q [NUM_COEF];
  logic [COEF_W-1:0] active_d [NUM_COEF];

  // Shadow write decode (reserved addresses match no entry) and swap copy.
  // Active copies the pre-write shadow, so a write in the swap cycle is not taken.
  always_comb begin
    for (int i = 0; i < NUM_COEF; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = swap ? shadow_q[i] : active_q[i];
      if (we && (addr == 3'(i))) begin
        shadow_d[i] = wdata;
      end
    end
  end

  // Coefficient storage; reset leaves the filter as a passthrough.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      shadow_q[ADDR_B0] <= COEF_ONE;
      active_q[ADDR_B0] <= COEF_ONE;
    end else begin
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

`ifdef IIR_CTRL_RDBK_EN
  logic [COEF_W-1:0] rdata_q;
  logic [COEF_W-1:0] rdata_d;

  // Readback mux over the shadow set; reserved addresses read as zero.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_COEF; i++) begin
      if (addr == 3'(i)) begin
        rdata_d = shadow_q[i];
      end
    end
  end

  // Readback register.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
`endif

  assign b0 = active_q[ADDR_B0];
  assign b1 = active_q[ADDR_B1];
  assign b2 = active_q[ADDR_B2];
  assign a1 = active_q[ADDR_A1];
  assign a2 = active_q[ADDR_A2];

endmodule

// File: rtl/iir_coef_ctrl.sv
// IIR coefficient controller: gates samples into the filter, and on a commit
// drains in-flight samples before atomically swapping in the shadow coefficients.
// Optional IIR_CTRL_RDBK_EN adds the cfg_rdata shadow readback port.
module iir_coef_ctrl
  import iir_pkg::*;
#(
  parameter int unsigned FILT_LAT = 2,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_wdata,
  input  logic              cfg_commit,
  output logic              cfg_busy,
  output logic              swap_done,
`ifdef IIR_CTRL_RDBK_EN
  output logic [COEF_W-1:0] cfg_rdata,
`endif
  input  logic              s_valid,
  input  logic [COEF_W-1:0] s_data,
  output logic              s_ready,
  output logic              f_vin,
  output logic [COEF_W-1:0] f_din,
  input  logic              f_vout,
  output logic [COEF_W-1:0] b0,
  output logic [COEF_W-1:0] b1,
  output logic [COEF_W-1:0] b2,
  output logic [COEF_W-1:0] a1,
  output logic [COEF_W-1:0] a2
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // FILT_LAT only documents the filter's latency; draining is completion-counted.
  if (FILT_LAT == 0) begin : g_zero_lat
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              f_vin_q, f_vin_d;
  logic [COEF_W-1:0] f_din_q, f_din_d;
  logic              swap_done_q, swap_done_d;
  logic              xfer;

  assign s_ready = (state_q == StRun);
  assign xfer    = s_valid & s_ready;

  // Next-state, in-flight count and registered output logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (cfg_commit) state_d = StDrain;
      StDrain: if ((cnt_q == '0) && !f_vin_q) state_d = StSwap;
      StSwap:  state_d = StRun;
      default: state_d = StRun;
    endcase

    cnt_d = cnt_q;
    if (f_vin_q && !f_vout) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (f_vout && !f_vin_q) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end

    f_vin_d     = xfer;
    f_din_d     = xfer ? s_data : f_din_q;
    swap_done_d = (state_q == StSwap);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      f_vin_q     <= 1'b0;
      f_din_q     <= '0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f_vin_q     <= f_vin_d;
      f_din_q     <= f_din_d;
      swap_done_q <= swap_done_d;
    end
  end

  assign cfg_busy  = (state_q != StRun);
  assign swap_done = swap_done_q;
  assign f_vin     = f_vin_q;
  assign f_din     = f_din_q;

  iir_coef_bank u_bank (
    .clock (clock),
    .rst_n (rst_n),
    .we    (cfg_we),
    .addr  (cfg_addr),
    .wdata (cfg_wdata),
    .swap  (state_q == StSwap),
`ifdef IIR_CTRL_RDBK_EN
    .rdata (cfg_rdata),
`endif
    .b0    (b0),
    .b1    (b1),
    .b2    (b2),
    .a1    (a1),
    .a2    (a2)
  );

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Self-checking bench for iir_coef_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model.
module tb_iir_coef_ctrl;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [8:0] cfg_wdata;
  logic       cfg_commit;
  logic       cfg_busy;
  logic       swap_done;
  logic       s_valid;
  logic [8:0] s_data;
  logic       s_ready;
  logic       f_vin;
  logic [8:0] f_din;
  logic       f_vout;
  logic [8:0] b0, b1, b2, a1, a2;
`ifdef IIR_CTRL_RDBK_EN
  logic [8:0] cfg_rdata;
`endif
  logic [8:0] dut_coef [5];

  int total = 0;
  int bad   = 0;

  // Model state: mode 0=run, 1=drain, 2=swap.
  int         m_mode;
  int         m_cnt;
  bit         m_fvin;
  logic [8:0] m_fdin;
  bit         m_sd;
  logic [8:0] m_sh  [5];
  logic [8:0] m_act [5];
  logic [8:0] m_rd;
  bit         auto_vout;
  bit         h0, h1, h2;

  always #5 clock = ~clock;

  assign dut_coef[0] = b0;
  assign dut_coef[1] = b1;
  assign dut_coef[2] = b2;
  assign dut_coef[3] = a1;
  assign dut_coef[4] = a2;

  iir_coef_ctrl dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_commit (cfg_commit),
    .cfg_busy   (cfg_busy),
    .swap_done  (swap_done),
`ifdef IIR_CTRL_RDBK_EN
    .cfg_rdata  (cfg_rdata),
`endif
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .f_vin      (f_vin),
    .f_din      (f_din),
    .f_vout     (f_vout),
    .b0         (b0),
    .b1         (b1),
    .b2         (b2),
    .a1         (a1),
    .a2         (a2)
  );

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_fvin = 0;
    m_fdin = '0;
    m_sd   = 0;
    m_rd   = '0;
    for (int i = 0; i < 5; i++) begin
      m_sh[i]  = (i == 0) ? 9'h040 : 9'h000;
      m_act[i] = m_sh[i];
    end
    h0 = 0; h1 = 0; h2 = 0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // optionally model a filter that answers each f_vin two cycles later.
  task automatic tick();
    int nmode;
    int a;
    @(posedge clock);
    if (!rst_n) begin
      model_reset();
    end else begin
      a     = int'(cfg_addr);
      nmode = m_mode;
      if (m_mode == 0 && cfg_commit) nmode = 1;
      if (m_mode == 1 && m_cnt == 0 && !m_fvin) nmode = 2;
      if (m_mode == 2) nmode = 0;
      m_sd = (m_mode == 2);
      if (m_mode == 2) for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
      m_rd = (a < 5) ? m_sh[a] : 9'h000;
      if (cfg_we && a < 5) m_sh[a] = cfg_wdata;
      if (m_fvin && !f_vout) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else if (f_vout && !m_fvin && m_cnt > 0) m_cnt = m_cnt - 1;
      if (s_valid && m_mode == 0) begin
        m_fvin = 1;
        m_fdin = s_data;
      end else begin
        m_fvin = 0;
      end
      m_mode = nmode;
    end
    #1;
    h2 = h1; h1 = h0; h0 = m_fvin;
    if (auto_vout) f_vout = h2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", cfg_busy); end
    total++; if (f_vin !== 1'b0) begin bad++; $display("FAIL reset_f_vin: got %b want 0", f_vin); end
    total++; if (f_din !== 9'h000) begin bad++; $display("FAIL reset_f_din: got %h want 000", f_din); end
    total++; if (swap_done !== 1'b0) begin bad++; $display("FAIL reset_swap_done: got %b want 0", swap_done); end
    total++; if (b0 !== 9'h040) begin bad++; $display("FAIL reset_b0: got %h want 040", b0); end
    total++; if ({b1, b2, a1, a2} !== 36'h0) begin bad++; $display("FAIL reset_others: got %h want 0", {b1, b2, a1, a2}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    s_valid = 1'b1; s_data = 9'h020;
    tick();
    s_valid = 1'b0; s_data = 9'h155;
    total++; if (f_vin !== 1'b1) begin bad++; $display("FAIL pass_f_vin: got %b want 1", f_vin); end
    total++; if (f_din !== 9'h020) begin bad++; $display("FAIL pass_f_din: got %h want 020", f_din); end
    tick();
    total++; if (f_vin !== 1'b0) begin bad++; $display("FAIL pass_f_vin_drop: got %b want 0", f_vin); end
    total++; if (f_din !== 9'h020) begin bad++; $display("FAIL pass_f_din_hold: got %h want 020", f_din); end
  endtask

  task automatic test_idle_commit();
    idle(3);
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 9'h1E0;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    total++; if (cfg_busy !== 1'b1 || s_ready !== 1'b0) begin bad++; $display("FAIL idle_drain: got busy=%b rdy=%b want 1/0", cfg_busy, s_ready); end
    total++; if (a1 !== 9'h000) begin bad++; $display("FAIL idle_a1_drain: got %h want 000", a1); end
    tick();
    total++; if (cfg_busy !== 1'b1 || swap_done !== 1'b0) begin bad++; $display("FAIL idle_swap: got busy=%b done=%b want 1/0", cfg_busy, swap_done); end
    total++; if (a1 !== 9'h000) begin bad++; $display("FAIL idle_a1_swap: got %h want 000", a1); end
    tick();
    total++; if (cfg_busy !== 1'b0 || swap_done !== 1'b1) begin bad++; $display("FAIL idle_run: got busy=%b done=%b want 0/1", cfg_busy, swap_done); end
    total++; if (a1 !== 9'h1E0) begin bad++; $display("FAIL idle_a1_new: got %h want 1e0", a1); end
    tick();
    total++; if (swap_done !== 1'b0) begin bad++; $display("FAIL idle_done_pulse: got %b want 0", swap_done); end
  endtask

  task automatic test_drain();
    int n;
    idle(4);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 9'(i + 1);
      tick();
    end
    s_valid = 1'b0;
    // write plus commit in the same cycle joins the swap
    cfg_commit = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 9'h07F;
    tick();
    cfg_commit = 1'b0; cfg_we = 1'b0;
    n = 0;
    while (cfg_busy === 1'b1 && n < 40) begin
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL drain_s_ready: got %b want 0", s_ready); end
      total++; if (b0 !== 9'h040) begin bad++; $display("FAIL drain_b0_early: got %h want 040", b0); end
      n++;
      tick();
    end
    total++; if (n != 4) begin bad++; $display("FAIL drain_busy_len: got %0d want 4", n); end
    total++; if (b0 !== 9'h07F || swap_done !== 1'b1) begin bad++; $display("FAIL drain_swap: got b0=%h done=%b want 07f/1", b0, swap_done); end
    total++; if (a1 !== 9'h1E0) begin bad++; $display("FAIL drain_a1_kept: got %h want 1e0", a1); end
  endtask

  task automatic test_swap_write();
    idle(4);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    total++; if (cfg_busy !== 1'b1) begin bad++; $display("FAIL swapw_in_swap: got %b want 1", cfg_busy); end
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 9'h010;
    tick();
    cfg_we = 1'b0;
    total++; if (b1 !== 9'h000 || swap_done !== 1'b1) begin bad++; $display("FAIL swapw_b1_old: got b1=%h done=%b want 000/1", b1, swap_done); end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick(); tick();
    total++; if (b1 !== 9'h010 || swap_done !== 1'b1) begin bad++; $display("FAIL swapw_b1_new: got b1=%h done=%b want 010/1", b1, swap_done); end
  endtask

  task automatic test_reset_drain();
    auto_vout = 1'b0; f_vout = 1'b0;
    idle(4);
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 9'h033;
    tick();
    cfg_we = 1'b0; s_valid = 1'b1; s_data = 9'h011;
    tick();
    s_valid = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick(); tick();
    total++; if (cfg_busy !== 1'b1) begin bad++; $display("FAIL rstd_stuck: got %b want 1", cfg_busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (b2 !== 9'h000 || b0 !== 9'h040) begin bad++; $display("FAIL rstd_active: got b2=%h b0=%h want 000/040", b2, b0); end
    total++; if (s_ready !== 1'b1 || cfg_busy !== 1'b0) begin bad++; $display("FAIL rstd_state: got rdy=%b busy=%b want 1/0", s_ready, cfg_busy); end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick(); tick();
    total++; if (b2 !== 9'h000 || swap_done !== 1'b1) begin bad++; $display("FAIL rstd_shadow: got b2=%h done=%b want 000/1", b2, swap_done); end
    auto_vout = 1'b1;
  endtask

  task automatic test_saturation();
    int n;
    auto_vout = 1'b0; f_vout = 1'b0;
    idle(2);
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = 9'($urandom_range(0, 511));
      tick();
    end
    s_valid = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0; f_vout = 1'b1;
    n = 0;
    while (cfg_busy === 1'b1 && n < 60) begin
      n++;
      tick();
    end
    // count caps at 15: 16 drain cycles plus the swap cycle
    total++; if (n != 17) begin bad++; $display("FAIL sat_busy_len: got %0d want 17", n); end
    tick();
    f_vout = 1'b0;
    s_valid = 1'b1; s_data = 9'h0AA;
    tick();
    s_valid = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick(); tick();
    // count stayed at 0 despite extra f_vout, so the next drain is stuck on one sample
    total++; if (cfg_busy !== 1'b1) begin bad++; $display("FAIL sat_floor: got %b want 1", cfg_busy); end
    f_vout = 1'b1;
    tick();
    f_vout = 1'b0;
    tick(); tick();
    total++; if (cfg_busy !== 1'b0 || swap_done !== 1'b1) begin bad++; $display("FAIL sat_release: got busy=%b done=%b want 0/1", cfg_busy, swap_done); end
    auto_vout = 1'b1;
  endtask

`ifdef IIR_CTRL_RDBK_EN
  task automatic test_readback();
    cfg_we = 1'b1; cfg_addr = 3'd4; cfg_wdata = 9'h1FF;
    tick();
    cfg_we = 1'b0;
    tick();
    total++; if (cfg_rdata !== 9'h1FF) begin bad++; $display("FAIL rdbk_a2: got %h want 1ff", cfg_rdata); end
    cfg_addr = 3'd6;
    tick();
    total++; if (cfg_rdata !== 9'h000) begin bad++; $display("FAIL rdbk_rsvd: got %h want 000", cfg_rdata); end
  endtask
`endif

  task automatic test_random();
    auto_vout = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      s_valid    = ($urandom_range(0, 1) == 1);
      s_data     = 9'($urandom_range(0, 511));
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_addr   = 3'($urandom_range(0, 7));
      cfg_wdata  = 9'($urandom_range(0, 511));
      cfg_commit = ($urandom_range(0, 9) == 0);
      f_vout     = ($urandom_range(0, 2) == 0);
      tick();
      total++; if (s_ready !== (m_mode == 0) || cfg_busy !== (m_mode != 0)) begin
        bad++; $display("FAIL rnd_state c=%0d: got rdy=%b busy=%b want mode %0d", c, s_ready, cfg_busy, m_mode);
      end
      total++; if (swap_done !== m_sd) begin bad++; $display("FAIL rnd_done c=%0d: got %b want %b", c, swap_done, m_sd); end
      total++; if (f_vin !== m_fvin || f_din !== m_fdin) begin
        bad++; $display("FAIL rnd_fout c=%0d: got %b/%h want %b/%h", c, f_vin, f_din, m_fvin, m_fdin);
      end
      for (int i = 0; i < 5; i++) begin
        total++; if (dut_coef[i] !== m_act[i]) begin
          bad++; $display("FAIL rnd_coef%0d c=%0d: got %h want %h", i, c, dut_coef[i], m_act[i]);
        end
      end
`ifdef IIR_CTRL_RDBK_EN
      total++; if (cfg_rdata !== m_rd) begin bad++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, cfg_rdata, m_rd); end
`endif
    end
    rst_n = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0; s_valid = 1'b0; f_vout = 1'b0;
    auto_vout = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 9'h000; cfg_commit = 1'b0;
    s_valid = 1'b0; s_data = 9'h000; f_vout = 1'b0; auto_vout = 1'b1;
    model_reset();
    test_reset();
    test_passthrough();
    test_idle_commit();
    test_drain();
    test_swap_write();
    test_reset_drain();
    test_saturation();
`ifdef IIR_CTRL_RDBK_EN
    test_readback();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
